// File: rtl/fifo_ring.sv
// Pointer-based circular FIFO with level/edge request qualification, thresholds, flush and sticky errors.
// Optional peak-occupancy output max_level is enabled with `define FIFO_MAXLEVEL_EN.
module fifo_ring #(
   parameter int DATA_WIDTH      = 32,
   parameter int FIFO_LENGTH     = 16,
   parameter int COUNTER_SIZE    = $clog2(FIFO_LENGTH + 1),
   parameter int PTR_SIZE        = $clog2(FIFO_LENGTH),
   parameter int ALMOST_FULL_TH  = FIFO_LENGTH - 2,
   parameter int ALMOST_EMPTY_TH = 2,
   parameter int EDGE_MODE       = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   data_i,
   input  logic                    push,
   output logic [DATA_WIDTH-1:0]   data_o,
   input  logic                    drop,
   input  logic                    flush,
   input  logic                    clear_err,
   output logic                    fifo_empty,
   output logic                    fifo_full,
   output logic                    almost_empty,
   output logic                    almost_full,
   output logic [COUNTER_SIZE-1:0] awaiting_count,
   output logic                    overflow,
   output logic                    underflow
`ifdef FIFO_MAXLEVEL_EN
   ,
   output logic [COUNTER_SIZE-1:0] max_level
`endif
);

   localparam logic [COUNTER_SIZE-1:0] FULL_CNT = COUNTER_SIZE'(FIFO_LENGTH);
   localparam logic [COUNTER_SIZE-1:0] AF_TH    = COUNTER_SIZE'(ALMOST_FULL_TH);
   localparam logic [COUNTER_SIZE-1:0] AE_TH    = COUNTER_SIZE'(ALMOST_EMPTY_TH);
   localparam logic [PTR_SIZE-1:0]     LAST_PTR = PTR_SIZE'(FIFO_LENGTH - 1);

   generate
      if (FIFO_LENGTH < 2) begin : g_bad_len
         $error("fifo_ring: FIFO_LENGTH must be at least 2");
      end
      if (ALMOST_FULL_TH > FIFO_LENGTH) begin : g_bad_af
         $error("fifo_ring: ALMOST_FULL_TH must not exceed FIFO_LENGTH");
      end
      if (ALMOST_EMPTY_TH >= FIFO_LENGTH) begin : g_bad_ae
         $error("fifo_ring: ALMOST_EMPTY_TH must be below FIFO_LENGTH");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] mem [FIFO_LENGTH];
   logic [PTR_SIZE-1:0]   wr_ptr, rd_ptr;
   logic                  push_q, drop_q;
   logic                  wr_en, rd_en;
   logic                  ovf_set, unf_set;

   function automatic logic [PTR_SIZE-1:0] ptr_inc(input logic [PTR_SIZE-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // History registers keep sampling through flush so edges are never replayed.
   generate
      if (EDGE_MODE != 0) begin : g_edge
         logic push_d, drop_d;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               push_d <= 1'b0;
               drop_d <= 1'b0;
            end else begin
               push_d <= push;
               drop_d <= drop;
            end
         end
         assign push_q = push & ~push_d;
         assign drop_q = drop & ~drop_d;
      end else begin : g_level
         assign push_q = push;
         assign drop_q = drop;
      end
   endgenerate

   assign fifo_empty   = (awaiting_count == '0);
   assign fifo_full    = (awaiting_count == FULL_CNT);
   assign almost_empty = (awaiting_count <= AE_TH);
   assign almost_full  = (awaiting_count >= AF_TH);

   // A drop on a full FIFO frees the slot the simultaneous push needs.
   assign wr_en   = ~flush & push_q & (~fifo_full | drop_q);
   assign rd_en   = ~flush & drop_q & ~fifo_empty;
   assign ovf_set = ~flush & push_q & fifo_full & ~drop_q;
   assign unf_set = ~flush & drop_q & fifo_empty;

   assign data_o = fifo_empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= data_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         awaiting_count <= '0;
      end else if (flush) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         awaiting_count <= '0;
      end else begin
         if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
         case ({wr_en, rd_en})
            2'b10:   awaiting_count <= awaiting_count + COUNTER_SIZE'(1);
            2'b01:   awaiting_count <= awaiting_count - COUNTER_SIZE'(1);
            default: awaiting_count <= awaiting_count;
         endcase
      end
   end

   // A new error in the same cycle as clear_err wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (ovf_set)        overflow <= 1'b1;
         else if (clear_err) overflow <= 1'b0;
         if (unf_set)        underflow <= 1'b1;
         else if (clear_err) underflow <= 1'b0;
      end
   end

`ifdef FIFO_MAXLEVEL_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                           max_level <= '0;
      else if (flush || clear_err)       max_level <= '0;
      else if (awaiting_count > max_level) max_level <= awaiting_count;
   end
`endif

endmodule

// File: tb/tb_fifo_ring.sv
// Directed scoreboard bench for fifo_ring: level-mode instance (depth 5, almost_full at 3)
// plus an edge-mode instance for request qualification.
module tb_fifo_ring;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] data1 = '0, data2 = '0;
   logic        push1 = 1'b0, drop1 = 1'b0, flush1 = 1'b0, clr1 = 1'b0;
   logic        push2 = 1'b0, drop2 = 1'b0;
   logic [31:0] dout1, dout2;
   logic        empty1, full1, ae1, af1, ovf1, unf1;
   logic        empty2, full2, ae2, af2, ovf2, unf2;
   logic [2:0]  cnt1, cnt2;
`ifdef FIFO_MAXLEVEL_EN
   logic [2:0]  ml1, ml2;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   fifo_ring #(.DATA_WIDTH(32), .FIFO_LENGTH(5), .ALMOST_FULL_TH(3), .EDGE_MODE(0)) u1 (
      .clk(clk), .rst(rst), .data_i(data1), .push(push1), .data_o(dout1), .drop(drop1),
      .flush(flush1), .clear_err(clr1), .fifo_empty(empty1), .fifo_full(full1),
      .almost_empty(ae1), .almost_full(af1), .awaiting_count(cnt1),
      .overflow(ovf1), .underflow(unf1)
`ifdef FIFO_MAXLEVEL_EN
      , .max_level(ml1)
`endif
   );

   fifo_ring #(.DATA_WIDTH(32), .FIFO_LENGTH(5), .EDGE_MODE(1)) u2 (
      .clk(clk), .rst(rst), .data_i(data2), .push(push2), .data_o(dout2), .drop(drop2),
      .flush(1'b0), .clear_err(1'b0), .fifo_empty(empty2), .fifo_full(full2),
      .almost_empty(ae2), .almost_full(af2), .awaiting_count(cnt2),
      .overflow(ovf2), .underflow(unf2)
`ifdef FIFO_MAXLEVEL_EN
      , .max_level(ml2)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted drop on u1 must present the oldest expected word.
   always @(negedge clk) begin
      if (!rst && !flush1 && drop1 && !empty1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: got 0x%0h expected no data", dout1);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (dout1 !== e) begin
               n_err++;
               $display("FAIL sb_data: got 0x%0h expected 0x%0h", dout1, e);
            end
         end
      end
   end

   initial begin
      int af_tab[5];
      af_tab = '{0, 0, 1, 1, 1};

      // Reset state while rst is held
      tick(); tick();
      check("rst_empty", 32'(empty1), 1);
      check("rst_full", 32'(full1), 0);
      check("rst_ae", 32'(ae1), 1);
      check("rst_af", 32'(af1), 0);
      check("rst_dout", dout1, 0);
      check("rst_cnt", 32'(cnt1), 0);
      rst = 1'b0;
      tick();

      // 1: fill with 0x11..0x55, then drain in order
      for (int i = 0; i < 5; i++) begin
         push1 = 1'b1;
         data1 = 32'h11 * (i + 1);
         exp_q.push_back(32'h11 * (i + 1));
         tick();
         check("t1_cnt", 32'(cnt1), i + 1);
         check("t1_af", 32'(af1), 32'(af_tab[i]));
      end
      push1 = 1'b0;
      check("t1_full", 32'(full1), 1);
      drop1 = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      drop1 = 1'b0;
      check("t1_empty", 32'(empty1), 1);
      check("t1_dout0", dout1, 0);

      // 2: wrap-around, four rounds of push 3 / drop 3 with values 1..12
      for (int r = 0; r < 4; r++) begin
         push1 = 1'b1;
         for (int k = 0; k < 3; k++) begin
            data1 = 32'(r * 3 + k + 1);
            exp_q.push_back(32'(r * 3 + k + 1));
            tick();
         end
         push1 = 1'b0;
         drop1 = 1'b1;
         for (int k = 0; k < 3; k++) tick();
         drop1 = 1'b0;
      end
      check("t2_cnt", 32'(cnt1), 0);

      // 3: overflow, push+drop when full, clear_err
      push1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         data1 = 32'h100 + 32'(i);
         exp_q.push_back(32'h100 + 32'(i));
         tick();
      end
      data1 = 32'hDEAD;
      tick();
      push1 = 1'b0;
      check("t3_ovf", 32'(ovf1), 1);
      check("t3_cnt_ovf", 32'(cnt1), 5);
      push1 = 1'b1; drop1 = 1'b1; data1 = 32'h200;
      exp_q.push_back(32'h200);
      tick();
      push1 = 1'b0; drop1 = 1'b0;
      check("t3_cnt_pd", 32'(cnt1), 5);
      check("t3_ovf_kept", 32'(ovf1), 1);
      clr1 = 1'b1;
      tick();
      clr1 = 1'b0;
      check("t3_ovf_clr", 32'(ovf1), 0);
      drop1 = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      drop1 = 1'b0;
      check("t3_empty", 32'(empty1), 1);

      // 4: push and drop on empty
      push1 = 1'b1; drop1 = 1'b1; data1 = 32'hA5;
      exp_q.push_back(32'hA5);
      tick();
      push1 = 1'b0; drop1 = 1'b0;
      check("t4_unf", 32'(unf1), 1);
      check("t4_cnt", 32'(cnt1), 1);
      check("t4_dout", dout1, 32'hA5);
      drop1 = 1'b1;
      tick();
      drop1 = 1'b0;
      clr1 = 1'b1;
      tick();
      clr1 = 1'b0;
      check("t4_unf_clr", 32'(unf1), 0);

      // 5: edge mode, held push and held drop
      push2 = 1'b1; data2 = 32'h7;
      for (int i = 0; i < 4; i++) tick();
      push2 = 1'b0;
      check("t5_cnt", 32'(cnt2), 1);
      check("t5_dout", dout2, 32'h7);
      drop2 = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      drop2 = 1'b0;
      check("t5_cnt0", 32'(cnt2), 0);
      check("t5_unf", 32'(unf2), 0);

      // 6: flush with push high keeps error flags
      drop1 = 1'b1;
      tick();
      drop1 = 1'b0;
      check("t6_unf_set", 32'(unf1), 1);
      push1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         data1 = 32'h30 + 32'(i);
         tick();
      end
      push1 = 1'b0;
      tick();
      check("t6_cnt3", 32'(cnt1), 3);
`ifdef FIFO_MAXLEVEL_EN
      check("t6_ml3", 32'(ml1), 3);
`endif
      flush1 = 1'b1; push1 = 1'b1; data1 = 32'h99;
      tick();
      flush1 = 1'b0; push1 = 1'b0;
      check("t6_cnt0", 32'(cnt1), 0);
      check("t6_empty", 32'(empty1), 1);
      check("t6_unf_kept", 32'(unf1), 1);
      check("t6_ovf_kept", 32'(ovf1), 0);
`ifdef FIFO_MAXLEVEL_EN
      check("t6_ml0", 32'(ml1), 0);
`endif

      // Asynchronous reset in the middle of a write burst
      push1 = 1'b1; data1 = 32'h5A;
      tick();
      check("t6_pre_rst_cnt", 32'(cnt1), 1);
      #2 rst = 1'b1;
      #1;
      check("arst_cnt", 32'(cnt1), 0);
      check("arst_empty", 32'(empty1), 1);
      check("arst_dout", dout1, 0);
      check("arst_unf", 32'(unf1), 0);
      check("arst_ae", 32'(ae1), 1);
      push1 = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_cnt", 32'(cnt1), 0);
      check("sb_drained", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
